// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the pipeline stage registers:
//                occupancy-state encoding, per-stage payload widths and
//                the control-field bubble value.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Occupancy state encoding of a stage register
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_HALF  = ST_HALF,
        S_FULL  = ST_FULL
    } state_t;

    // Per-boundary control-field widths
    localparam int IFID_CTRL_W  = 4;
    localparam int IDEX_CTRL_W  = 18;
    localparam int EXMEM_CTRL_W = 8;
    localparam int MEMWB_CTRL_W = 4;

    // Per-boundary data-payload widths
    localparam int IFID_DATA_W  = 64;   // pc + instruction
    localparam int IDEX_DATA_W  = 32;
    localparam int EXMEM_DATA_W = 32;
    localparam int MEMWB_DATA_W = 32;

    // An all-zero control field is a NOP: nothing downstream acts on it
    localparam int CTRL_NOP = 0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_sat_counter
//  Description : Saturating up-counter with synchronous clear.
//                clk   : clock
//                reset : asynchronous active-low reset
//                inc   : count one event this cycle
//                clr   : synchronous clear, wins over inc
//                count : current value, holds at all-ones
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule : pipe_sat_counter
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_stage_reg
//  Description : Pipeline stage register with valid/ready handshake,
//                optional skid entry, synchronous flush (bubble insertion)
//                and a saturating stall-cycle counter.
//  Ports       : clk, reset (async active-low)
//                in_valid / in_ready / in_ctrl / in_data   : upstream side
//                out_valid / out_ready / out_ctrl / out_data : downstream
//                flush        : squash all held entries
//                stall_cycles : cycles with out_valid && !out_ready
//                stall_clr    : synchronous clear of stall_cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W   = 18,
    parameter int DATA_W   = 32,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 0,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cycles,
    input  logic              stall_clr
);

    localparam bit c_skid_en  = (SKID != 0);
    localparam bit c_clr_data = (CLR_DATA != 0);
    localparam logic [CTRL_W-1:0] c_nop = CTRL_W'(CTRL_NOP);

    state_t            r_state,     w_state_nxt;
    logic [CTRL_W-1:0] r_main_ctrl, w_main_ctrl_nxt;
    logic [DATA_W-1:0] r_main_data, w_main_data_nxt;
    logic [CTRL_W-1:0] r_skid_ctrl, w_skid_ctrl_nxt;
    logic [DATA_W-1:0] r_skid_data, w_skid_data_nxt;

    logic w_ix;
    logic w_ox;

    assign out_valid = (r_state != S_EMPTY);
    assign w_ix      = in_valid && in_ready;
    assign w_ox      = out_valid && out_ready;

    // ------------------------------------------------------------------
    // Upstream ready
    // ------------------------------------------------------------------
    generate
        if (c_skid_en) begin : g_skid_ready
            // Registered so the ready path does not ripple back through
            // the whole pipeline; the skid entry absorbs the one beat
            // that may arrive after downstream stalls.
            logic r_in_ready;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_in_ready <= 1'b0;
                end else begin
                    r_in_ready <= (w_state_nxt != S_FULL);
                end
            end
            assign in_ready = r_in_ready;
        end else begin : g_comb_ready
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and entry registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_EMPTY;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_main_data <= w_main_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and entry update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;

        if (flush) begin
            // An accepted input beat in this cycle is dropped; an output
            // beat in this cycle was already consumed downstream.
            w_state_nxt     = S_EMPTY;
            w_main_ctrl_nxt = c_nop;
            w_skid_ctrl_nxt = c_nop;
            if (c_clr_data) begin
                w_main_data_nxt = '0;
                w_skid_data_nxt = '0;
            end
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_ix) begin
                        w_state_nxt     = S_HALF;
                        w_main_ctrl_nxt = in_ctrl;
                        w_main_data_nxt = in_data;
                    end
                end
                S_HALF: begin
                    if (w_ix && w_ox) begin
                        w_main_ctrl_nxt = in_ctrl;
                        w_main_data_nxt = in_data;
                    end else if (w_ox) begin
                        w_state_nxt     = S_EMPTY;
                        w_main_ctrl_nxt = c_nop;
                        if (c_clr_data) begin
                            w_main_data_nxt = '0;
                        end
                    end else if (w_ix && c_skid_en) begin
                        w_state_nxt     = S_FULL;
                        w_skid_ctrl_nxt = in_ctrl;
                        w_skid_data_nxt = in_data;
                    end
                end
                S_FULL: begin
                    if (w_ox) begin
                        w_state_nxt     = S_HALF;
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_main_data_nxt = r_skid_data;
                        w_skid_ctrl_nxt = c_nop;
                        if (c_clr_data) begin
                            w_skid_data_nxt = '0;
                        end
                    end
                end
                default: begin
                    w_state_nxt     = S_EMPTY;
                    w_main_ctrl_nxt = c_nop;
                    w_skid_ctrl_nxt = c_nop;
                end
            endcase
        end
    end

    // Masked so the bubble is guaranteed whenever nothing is presented
    assign out_ctrl = out_valid ? r_main_ctrl : c_nop;
    assign out_data = r_main_data;

    // ------------------------------------------------------------------
    // Stall-cycle counter
    // ------------------------------------------------------------------
    pipe_sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready),
        .clr   (stall_clr),
        .count (stall_cycles)
    );

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_stage_reg
//  Description : Self-checking bench. Three instances:
//                  A : SKID=1, CLR_DATA=0, CNT_W=4
//                  B : SKID=1, CLR_DATA=1, CNT_W=16 (same inputs as A)
//                  C : SKID=0, own upstream/downstream signals
//                Accepted beats are queued per instance and compared when
//                the instance delivers them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CW = 18;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset     = 1'b0;
    logic          in_valid  = 1'b0;
    logic [CW-1:0] in_ctrl   = '0;
    logic [DW-1:0] in_data   = '0;
    logic          flush     = 1'b0;
    logic          out_ready = 1'b0;
    logic          stall_clr = 1'b0;

    logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [CW-1:0] a_out_ctrl, b_out_ctrl;
    logic [DW-1:0] a_out_data, b_out_data;
    logic [3:0]    a_stall;
    logic [15:0]   b_stall;

    logic          c_in_valid  = 1'b0;
    logic [CW-1:0] c_in_ctrl   = '0;
    logic [DW-1:0] c_in_data   = '0;
    logic          c_out_ready = 1'b0;
    logic          c_flush     = 1'b0;
    logic          c_stall_clr = 1'b0;
    logic          c_in_ready, c_out_valid;
    logic [CW-1:0] c_out_ctrl;
    logic [DW-1:0] c_out_data;
    logic [15:0]   c_stall;

    int checks   = 0;
    int failures = 0;

    logic [CW+DW-1:0] aq[$];
    logic [CW+DW-1:0] bq[$];
    logic [CW+DW-1:0] cq[$];

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(0), .CNT_W(4)) u_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
        .stall_cycles(a_stall), .stall_clr(stall_clr));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(1), .CNT_W(16)) u_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
        .stall_cycles(b_stall), .stall_clr(stall_clr));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLR_DATA(0), .CNT_W(16)) u_c (
        .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_ctrl(c_in_ctrl), .in_data(c_in_data), .flush(c_flush), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_ctrl(c_out_ctrl), .out_data(c_out_data),
        .stall_cycles(c_stall), .stall_clr(c_stall_clr));

    // Scoreboard: sampled mid-cycle, when handshakes for the next edge are settled
    task automatic scoreboard();
        logic [CW+DW-1:0] exp;
        if (a_out_valid && out_ready) begin
            checks++;
            if (aq.size() == 0) begin
                failures++; $display("FAIL sb_a_extra: got %h want no beat", {a_out_ctrl, a_out_data});
            end else begin
                exp = aq.pop_front();
                if ({a_out_ctrl, a_out_data} !== exp) begin
                    failures++; $display("FAIL sb_a_beat: got %h want %h", {a_out_ctrl, a_out_data}, exp);
                end
            end
        end
        if (b_out_valid && out_ready) begin
            checks++;
            if (bq.size() == 0) begin
                failures++; $display("FAIL sb_b_extra: got %h want no beat", {b_out_ctrl, b_out_data});
            end else begin
                exp = bq.pop_front();
                if ({b_out_ctrl, b_out_data} !== exp) begin
                    failures++; $display("FAIL sb_b_beat: got %h want %h", {b_out_ctrl, b_out_data}, exp);
                end
            end
        end
        if (c_out_valid && c_out_ready) begin
            checks++;
            if (cq.size() == 0) begin
                failures++; $display("FAIL sb_c_extra: got %h want no beat", {c_out_ctrl, c_out_data});
            end else begin
                exp = cq.pop_front();
                if ({c_out_ctrl, c_out_data} !== exp) begin
                    failures++; $display("FAIL sb_c_beat: got %h want %h", {c_out_ctrl, c_out_data}, exp);
                end
            end
        end
        if (flush) begin
            aq.delete();
            bq.delete();
        end else begin
            if (in_valid && a_in_ready) aq.push_back({in_ctrl, in_data});
            if (in_valid && b_in_ready) bq.push_back({in_ctrl, in_data});
        end
        if (c_in_valid && c_in_ready) cq.push_back({c_in_ctrl, c_in_data});
    endtask

    task automatic tick();
        @(negedge clk);
        scoreboard();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
        checks++; if (a_out_ctrl !== '0) begin failures++; $display("FAIL rst_out_ctrl: got %h want 0", a_out_ctrl); end
        checks++; if (a_out_data !== '0) begin failures++; $display("FAIL rst_out_data: got %h want 0", a_out_data); end
        checks++; if (a_stall !== 4'd0) begin failures++; $display("FAIL rst_stall: got %0d want 0", a_stall); end
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready: got %b want 0", a_in_ready); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL rel_in_ready_early: got %b want 0", a_in_ready); end
        tick();
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL rel_in_ready: got %b want 1", a_in_ready); end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CW'(i + 1);
            in_data  = DW'(32'h11 + i);
            tick();
            checks++;
            if (a_out_valid !== 1'b1 || a_out_data !== DW'(32'h11 + i)) begin
                failures++; $display("FAIL stream_beat%0d: got v=%b d=%h want v=1 d=%h", i, a_out_valid, a_out_data, 32'h11 + i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== '0) begin failures++; $display("FAIL stream_bubble: got v=%b c=%h want v=0 c=0", a_out_valid, a_out_ctrl); end
        checks++; if (a_out_data !== 32'h14) begin failures++; $display("FAIL stream_a_hold: got %h want 14", a_out_data); end
        checks++; if (b_out_data !== 32'h0) begin failures++; $display("FAIL stream_b_clr: got %h want 0", b_out_data); end
    endtask

    task automatic test_stall_fill();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_ctrl = 18'h1; in_data = 32'hA1;
        tick();
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL fill_ready_half: got %b want 1", a_in_ready); end
        in_ctrl = 18'h2; in_data = 32'hA2;
        tick();
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL fill_ready_full: got %b want 0", a_in_ready); end
        checks++; if (a_stall !== 4'd1) begin failures++; $display("FAIL fill_stall1: got %0d want 1", a_stall); end
        in_ctrl = 18'h3; in_data = 32'hA3;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (a_in_ready !== 1'b0 || a_stall !== 4'(2 + k)) begin
                failures++; $display("FAIL fill_hold%0d: got rdy=%b stall=%0d want rdy=0 stall=%0d", k, a_in_ready, a_stall, 2 + k);
            end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (a_out_data !== 32'hA2 || a_in_ready !== 1'b1 || a_stall !== 4'd4) begin
            failures++; $display("FAIL drain1: got d=%h rdy=%b stall=%0d want d=a2 rdy=1 stall=4", a_out_data, a_in_ready, a_stall);
        end
        tick();
        checks++; if (a_out_data !== 32'hA3) begin failures++; $display("FAIL drain2: got %h want a3", a_out_data); end
        in_valid = 1'b0;
        tick();
        checks++; if (aq.size() != 0 || a_out_valid !== 1'b0) begin
            failures++; $display("FAIL drain_done: got pending=%0d v=%b want 0 0", aq.size(), a_out_valid);
        end
    endtask

    task automatic test_flush_full();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_ctrl = 18'h3FFFF; in_data = 32'hB1;
        tick();
        in_data = 32'hB2;
        tick();
        in_valid = 1'b0;
        checks++; if (a_in_ready !== 1'b0) begin failures++; $display("FAIL ff_full: got rdy=%b want 0", a_in_ready); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== '0 || a_in_ready !== 1'b1) begin
            failures++; $display("FAIL ff_state: got v=%b c=%h rdy=%b want 0 0 1", a_out_valid, a_out_ctrl, a_in_ready);
        end
        checks++; if (a_out_data !== 32'hB1) begin failures++; $display("FAIL ff_a_data: got %h want b1", a_out_data); end
        checks++; if (b_out_data !== 32'h0 || b_out_ctrl !== '0) begin failures++; $display("FAIL ff_b_data: got c=%h d=%h want 0 0", b_out_ctrl, b_out_data); end
        checks++; if (a_stall !== 4'd6 || b_stall !== 16'd6) begin
            failures++; $display("FAIL ff_stall: got a=%0d b=%0d want 6 6", a_stall, b_stall);
        end
    endtask

    task automatic test_flush_concurrent();
        out_ready = 1'b1;
        in_valid  = 1'b1; in_ctrl = 18'h5; in_data = 32'hC1;
        tick();
        in_ctrl = 18'h6; in_data = 32'h55; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== '0) begin
            failures++; $display("FAIL fc_bubble: got v=%b c=%h want 0 0", a_out_valid, a_out_ctrl);
        end
        tick();
        tick();
        checks++; if (a_out_valid !== 1'b0 || aq.size() != 0) begin
            failures++; $display("FAIL fc_dropped: got v=%b pending=%0d want 0 0", a_out_valid, aq.size());
        end
    endtask

    task automatic test_counter_sat();
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        checks++; if (a_stall !== 4'd0) begin failures++; $display("FAIL sat_clr0: got %0d want 0", a_stall); end
        out_ready = 1'b0;
        in_valid  = 1'b1; in_ctrl = 18'h7; in_data = 32'hD1;
        tick();
        in_valid = 1'b0;
        repeat (20) tick();
        checks++; if (a_stall !== 4'd15) begin failures++; $display("FAIL sat_a: got %0d want 15", a_stall); end
        checks++; if (b_stall !== 16'd20) begin failures++; $display("FAIL sat_b: got %0d want 20", b_stall); end
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        checks++; if (a_stall !== 4'd0 || b_stall !== 16'd0) begin
            failures++; $display("FAIL sat_clr_wins: got a=%0d b=%0d want 0 0", a_stall, b_stall);
        end
        out_ready = 1'b1;
        tick();
        checks++; if (aq.size() != 0 || a_out_valid !== 1'b0) begin
            failures++; $display("FAIL sat_drain: got pending=%0d v=%b want 0 0", aq.size(), a_out_valid);
        end
    endtask

    task automatic test_skid0();
        bit pat [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bit exp_rdy;
        bit took;
        int cd = 0;
        c_in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            c_in_ctrl   = CW'(cd + 1);
            c_in_data   = DW'(32'h100 + cd);
            c_out_ready = pat[k];
            #1;
            exp_rdy = (cq.size() == 0) || pat[k];
            checks++;
            if (c_in_ready !== exp_rdy) begin
                failures++; $display("FAIL skid0_ready%0d: got %b want %b", k, c_in_ready, exp_rdy);
            end
            took = c_in_ready;
            tick();
            if (took) cd++;
        end
        c_in_valid  = 1'b0;
        c_out_ready = 1'b1;
        tick();
        tick();
        checks++; if (cq.size() != 0 || c_out_valid !== 1'b0 || cd < 6) begin
            failures++; $display("FAIL skid0_drain: got pending=%0d v=%b accepted=%0d want 0 0 >=6", cq.size(), c_out_valid, cd);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1; in_ctrl = 18'h9; in_data = 32'hE1;
        tick();
        in_data = 32'hE2;
        tick();
        in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
            failures++; $display("FAIL ar_full: got v=%b rdy=%b want 1 0", a_out_valid, a_in_ready);
        end
        #2;
        reset = 1'b0;
        aq.delete();
        bq.delete();
        cq.delete();
        #1;
        checks++; if (a_out_valid !== 1'b0 || a_out_ctrl !== '0 || a_out_data !== '0 || a_stall !== 4'd0) begin
            failures++; $display("FAIL ar_immediate: got v=%b c=%h d=%h s=%0d want all 0", a_out_valid, a_out_ctrl, a_out_data, a_stall);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick();
        checks++; if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            failures++; $display("FAIL ar_recover: got rdy=%b v=%b want 1 0", a_in_ready, a_out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_fill();
        test_flush_full();
        test_flush_concurrent();
        test_counter_sat();
        test_skid0();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
